// File: rtl/hub75_row_reader.sv
// hub75_row_reader: pulls WIDTH serial bits from a shift-on-request
// source, clocks them into one HUB75 colour line, then latches and
// displays the row for ON_CYCLES clocks before advancing the row address.
//
// Ports:
//   clk, rst (async, active-low)
//   start       request one row (sampled in IDLE only)
//   in_channel  serial pixel bit from the source
//   shift       one-cycle advance request to the source
//   r_data      HUB75 colour data
//   pclk        HUB75 column clock
//   lat         HUB75 latch strobe
//   oe          HUB75 output enable, active-low
//   row         HUB75 row address
//   busy        not idle
//   row_done    pulse in the first idle cycle after a row
module hub75_row_reader #(
    parameter int WIDTH     = 64,
    parameter int ROW_BITS  = 4,
    parameter int ON_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_channel,
    output logic                shift,
    output logic                r_data,
    output logic                pclk,
    output logic                lat,
    output logic                oe,
    output logic [ROW_BITS-1:0] row,
    output logic                busy,
    output logic                row_done
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW =
        (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        SETUP,
        CLKHI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] on_cnt;
    logic          last_bit;

    assign last_bit = (bit_cnt == BW'(WIDTH - 1));

    // Strobes decode straight from registered state, so no
    // input ever reaches an output combinationally.
    assign pclk  = (state == CLKHI);
    assign shift = pclk && !last_bit;
    assign lat   = (state == LATCH);
    assign oe    = (state != DISPLAY);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            on_cnt   <= '0;
            r_data   <= 1'b0;
            row      <= '0;
            row_done <= 1'b0;
        end else begin
            row_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        state   <= SETTLE;
                    end
                end
                SETTLE:
                    state <= SAMPLE;
                SAMPLE: begin
                    r_data <= in_channel;
                    state  <= SETUP;
                end
                SETUP:
                    state <= CLKHI;
                CLKHI: begin
                    if (last_bit) begin
                        state <= BLANK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= SETTLE;
                    end
                end
                BLANK:
                    state <= LATCH;
                LATCH: begin
                    on_cnt <= CW'(ON_CYCLES - 1);
                    state  <= DISPLAY;
                end
                DISPLAY: begin
                    if (on_cnt == '0) begin
                        row      <= row + 1'b1;
                        row_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        on_cnt <= on_cnt - 1'b1;
                    end
                end
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_row_reader.sv
// tb_hub75_row_reader: directed stimulus with a timing-rule model
// checked every cycle, plus literal row-level expectations.
module tb_hub75_row_reader;

    localparam int W   = 64;
    localparam int ON  = 256;
    localparam int P   = 4 * W + 2 + ON;
    localparam logic [63:0] WORD = 64'h391EABCE0AB8DE7F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       src_clr = 1'b0;
    logic [63:0] src_word = '0;
    logic [5:0] src_idx = '0;
    logic       in_channel;
    logic       shift, r_data, pclk, lat, oe, busy, row_done;
    logic [3:0] row;

    logic       start2 = 1'b0;
    logic       src2_clr = 1'b0;
    logic [3:0] src2_word = 4'b0110;
    logic [1:0] src2_idx = '0;
    logic       in2;
    logic       shift2, r_data2, pclk2, lat2, oe2, busy2, row_done2;
    logic [3:0] row2;

    int tcyc = 0;
    int checks = 0;
    int errors = 0;

    assign in_channel = src_word[src_idx];
    assign in2        = src2_word[src2_idx];

    hub75_row_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_channel(in_channel), .shift(shift),
        .r_data(r_data), .pclk(pclk), .lat(lat),
        .oe(oe), .row(row), .busy(busy),
        .row_done(row_done)
    );

    hub75_row_reader #(.WIDTH(4), .ROW_BITS(4), .ON_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .in_channel(in2), .shift(shift2),
        .r_data(r_data2), .pclk(pclk2), .lat(lat2),
        .oe(oe2), .row(row2), .busy(busy2),
        .row_done(row_done2)
    );

    // Shift-on-request sources: advance on each shift pulse,
    // rewound by the sequencer (src_clr) or at row end.
    always @(posedge clk) begin
        tcyc <= tcyc + 1;
        if (src_clr || row_done)
            src_idx <= '0;
        else if (shift)
            src_idx <= src_idx + 1'b1;
        if (src2_clr || row_done2)
            src2_idx <= '0;
        else if (shift2)
            src2_idx <= src2_idx + 1'b1;
    end

    // Model: row timeline relative to the first SETTLE cycle n0.
    bit         active = 1'b0;
    int         n0 = 0;
    logic [3:0] m_row = '0;
    logic       m_rd = 1'b0;
    int         mt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            m_row  <= '0;
            m_rd   <= 1'b0;
        end else begin
            mt = tcyc - n0;
            if (active && mt == P - 1)
                m_row <= m_row + 1'b1;
            if (active && mt < 4 * W && mt % 4 == 1)
                m_rd <= src_word[mt / 4];
            if ((!active || mt >= P) && start) begin
                active <= 1'b1;
                n0     <= tcyc + 1;
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, tcyc);
        end
    endtask

    int tot_shift = 0, tot_lat = 0, tot_oe0 = 0, tot_pclk = 0;
    int tot_rd = 0, rd_cyc = 0;
    logic [3:0] rd_row = '0;
    logic [63:0] cap_word = '0;
    int tot2_shift = 0, tot2_pclk = 0, tot2_rd = 0, rd2_cyc = 0;
    logic [3:0] cap2 = '0;
    logic [3:0] rd2_row = '0;

    // Compare process: every cycle outside reset.
    initial begin
        int  t;
        bit  in_row, e_pclk, e_shift, e_lat;
        bit  e_oe, e_busy, e_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                t       = tcyc - n0;
                in_row  = active && t >= 0 && t < 4 * W;
                e_pclk  = in_row && t % 4 == 3;
                e_shift = e_pclk && t / 4 < W - 1;
                e_lat   = active && t == 4 * W + 1;
                e_oe    = !(active && t >= 4 * W + 2 && t < P);
                e_busy  = active && t >= 0 && t < P;
                e_done  = active && t == P;
                chk("pclk", 64'(pclk), 64'(e_pclk));
                chk("shift", 64'(shift), 64'(e_shift));
                chk("lat", 64'(lat), 64'(e_lat));
                chk("oe", 64'(oe), 64'(e_oe));
                chk("busy", 64'(busy), 64'(e_busy));
                chk("row_done", 64'(row_done), 64'(e_done));
                chk("row", 64'(row), 64'(m_row));
                chk("r_data", 64'(r_data), 64'(m_rd));
                tot_shift += int'(shift);
                tot_lat   += int'(lat);
                tot_oe0   += int'(!oe);
                tot_pclk  += int'(pclk);
                if (pclk)
                    cap_word = {r_data, cap_word[63:1]};
                if (row_done) begin
                    tot_rd++;
                    rd_cyc = tcyc;
                    rd_row = row;
                end
                tot2_shift += int'(shift2);
                tot2_pclk  += int'(pclk2);
                if (pclk2)
                    cap2 = {r_data2, cap2[3:1]};
                if (row_done2) begin
                    tot2_rd++;
                    rd2_cyc = tcyc;
                    rd2_row = row2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input logic hold, output int n);
        start   = 1'b1;
        src_clr = 1'b1;
        n       = tcyc + 1;
        tick();
        start   = hold;
        src_clr = 1'b0;
    endtask

    task automatic wait_done(output int c);
        int base;
        base = tot_rd;
        c    = -1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (tot_rd != base) begin
                c = rd_cyc;
                break;
            end
        end
        #1;
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL row_done_timeout: got none expected pulse");
        end
    endtask

    initial begin
        int n, c, prev;
        int s0, l0, o0, p0;
        logic [3:0] er;

        // Reset with random inputs.
        src_word = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            start  = 1'($urandom % 2);
            start2 = 1'($urandom % 2);
            tick();
        end
        chk("rst_oe", 64'(oe), 64'd1);
        chk("rst_row", 64'(row), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_misc",
            64'({shift, r_data, pclk, lat, row_done}), 64'd0);
        chk("rst2_misc",
            64'({shift2, pclk2, lat2, busy2, oe2}), 64'd1);
        start  = 1'b0;
        start2 = 1'b0;
        rst    = 1'b1;
        repeat (5) tick();
        chk("idle_after_rst", 64'(busy), 64'd0);

        // Single row, default parameters.
        src_word = WORD;
        s0 = tot_shift; l0 = tot_lat;
        o0 = tot_oe0;   p0 = tot_pclk;
        start_row(1'b0, n);
        wait_done(c);
        chk("done_offset", 64'(c - n), 64'd514);
        chk("row_after", 64'(rd_row), 64'd1);
        chk("bits", cap_word, WORD);
        chk("first_byte", 64'(cap_word[7:0]), 64'h7F);
        chk("shift_cnt", 64'(tot_shift - s0), 64'd63);
        chk("lat_cnt", 64'(tot_lat - l0), 64'd1);
        chk("oe_low_cnt", 64'(tot_oe0 - o0), 64'd256);
        chk("pclk_cnt", 64'(tot_pclk - p0), 64'd64);

        // start in SAMPLE and DISPLAY is ignored.
        start_row(1'b0, n);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (298) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c);
        chk("ignored_start_offset", 64'(c - n), 64'd514);
        chk("row_two", 64'(rd_row), 64'd2);

        // Back-to-back rows with start held; row wraps 15 -> 0.
        er = 4'd2;
        start_row(1'b1, n);
        prev = n - 1;
        for (int i = 0; i < 17; i++) begin
            wait_done(c);
            if (i == 15)
                start = 1'b0;
            er = er + 1'b1;
            chk("wrap_row", 64'(rd_row), 64'(er));
            chk("wrap_period", 64'(c - prev), 64'd515);
            prev = c;
        end

        // Asynchronous reset during bit 20 SETUP.
        start_row(1'b0, n);
        repeat (82) tick();
        chk("bit20_rdata", 64'(r_data), 64'd1);
        chk("pre_rst_row", 64'(row), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rdata", 64'(r_data), 64'd0);
        chk("async_pclk", 64'(pclk), 64'd0);
        chk("async_shift", 64'(shift), 64'd0);
        chk("async_oe", 64'(oe), 64'd1);
        chk("async_row", 64'(row), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        p0 = tot_pclk;
        start_row(1'b0, n);
        wait_done(c);
        chk("post_rst_offset", 64'(c - n), 64'd514);
        chk("post_rst_bits", cap_word, WORD);
        chk("post_rst_pclk", 64'(tot_pclk - p0), 64'd64);
        chk("post_rst_row", 64'(rd_row), 64'd1);

        // Small instance: WIDTH=4, ON_CYCLES=2.
        s0 = tot2_shift;
        p0 = tot2_pclk;
        c  = tot2_rd;
        start2   = 1'b1;
        src2_clr = 1'b1;
        n        = tcyc + 1;
        tick();
        start2   = 1'b0;
        src2_clr = 1'b0;
        for (int i = 0; i < 100 && tot2_rd == c; i++)
            tick();
        chk("small_done", 64'(tot2_rd - c), 64'd1);
        chk("small_offset", 64'(rd2_cyc - n), 64'd20);
        chk("small_pclk", 64'(tot2_pclk - p0), 64'd4);
        chk("small_shift", 64'(tot2_shift - s0), 64'd3);
        chk("small_bits", 64'(cap2), 64'(src2_word));
        chk("small_row", 64'(rd2_row), 64'd1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_row_reader.md
# hub75_row_reader

Consumes the 1-bit serial pixel channel produced by a shift-on-request pixel source and drives one HUB75 colour line of the panel. For each row it requests `WIDTH` bits over the `shift`/`in_channel` handshake and clocks each bit into the panel with `pclk`. It then blanks, latches and displays the row for a fixed on-time before advancing the row address. It sits between the pixel source and the HUB75 connector, and is started one row at a time by the frame sequencer.

## Interface
- `WIDTH`, 64: pixels per row; bits requested per row (≥2).
- `ROW_BITS`, 4: width of the row address.
- `ON_CYCLES`, 256: display (`oe`=0) duration per row, in `clk` cycles (≥1).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one row; sampled only in IDLE.
- `in_channel`  in  1  serial pixel bit from the source.
- `shift`  out  1  one-cycle request to the source to advance to the next bit.
- `r_data`  out  1  HUB75 colour data line.
- `pclk`  out  1  HUB75 column shift clock.
- `lat`  out  1  HUB75 latch strobe.
- `oe`  out  1  HUB75 output enable, active-low (1 = panel blank).
- `row`  out  ROW_BITS  HUB75 row address.
- `busy`  out  1  high whenever the state is not IDLE.
- `row_done`  out  1  one-cycle pulse after a row's display period ends.

## Operation
- States: IDLE, SETTLE, SAMPLE, SETUP, CLKHI, BLANK, LATCH, DISPLAY.
- All outputs are registered or decoded from the state register; no combinational path runs from an input to an output.
- Reset values: `shift`=0, `pclk`=0, `lat`=0, `oe`=1, `r_data`=0, `row`=0, `busy`=0, `row_done`=0. The state goes to IDLE and the bit and on-time counters clear.
- IDLE: `start`=1 moves to SETTLE and clears the bit counter. `start` is ignored in every other state.
- SETTLE: `shift`=0. Gives the source a `shift`-low cycle to present the current bit.
- SAMPLE: `shift`=0. `r_data` <= `in_channel` on the exiting edge.
- SETUP: `r_data` is stable and `pclk`=0.
- CLKHI: `pclk`=1.
  - If bit count < `WIDTH`-1: `shift`=1 in the same cycle, the bit counter increments, and the next state is SETTLE.
  - If bit count = `WIDTH`-1: `shift`=0 and the next state is BLANK.
- Bits are taken LSB-first, in source order. Exactly `WIDTH`-1 `shift` pulses are issued per row.
- BLANK: `oe`=1 for 1 cycle.
- LATCH: `lat`=1 and `oe`=1 for 1 cycle. The on-time counter loads `ON_CYCLES`-1.
- DISPLAY: `oe`=0 and the counter decrements each cycle. At 0, the next state is IDLE.
- On the DISPLAY→IDLE edge:
  - `row` increments modulo 2^`ROW_BITS`, wrapping from 2^`ROW_BITS`-1 to 0.
  - `row_done`=1 for that first IDLE cycle only.
- `oe`=1 in every state except DISPLAY.
- Between rows, `r_data` holds the last sampled bit.
- Reset mid-operation: all outputs take their reset values immediately and asynchronously, any partial row is discarded, and `row` returns to 0. The source's position is not restored; the frame sequencer reloads the source.

## Timing
- Let cycle N be the first SETTLE cycle; `start` was accepted on the edge entering N.
- Each bit takes 4 cycles: SETTLE, SAMPLE, SETUP, CLKHI.
- Bit k: `r_data` is valid from cycle N+4k+2, and `pclk` is high in cycle N+4k+3.
- `shift` is high in cycle N+4k+3 for k < `WIDTH`-1.
- BLANK is at cycle N+4·`WIDTH` and LATCH at N+4·`WIDTH`+1.
- DISPLAY occupies cycles N+4·`WIDTH`+2 through N+4·`WIDTH`+1+`ON_CYCLES`.
- `row_done` and the new `row` value appear at N+4·`WIDTH`+2+`ON_CYCLES`; with defaults that is N+514.
- Back-to-back rows: `start` held high in the `row_done` cycle is accepted, so the next SETTLE begins 1 cycle later. The minimum row period is therefore 4·`WIDTH`+3+`ON_CYCLES`.
- `r_data` is stable for at least 1 full cycle before the `pclk` rise and remains stable through the high phase.

## Test plan
- Reset: hold `rst`=0 with random inputs → `oe`=1, `row`=0, `busy`=0, and all other outputs 0. Release reset with `start`=0 → the block stays in IDLE.
- One row, source loaded with 64'h391EABCE0AB8DE7F, defaults:
  - the 64 CLKHI cycles show `r_data` = the word's bits 0..63, LSB first (first byte 1,1,1,1,1,1,1,0);
  - exactly 63 `shift` pulses, 1 `lat` pulse, and `oe`=0 for exactly 256 cycles;
  - `row_done` at N+514, with `row` going 0→1.
- Row wrap: run 16 rows back-to-back with `start` held high → `row` counts 0..15 then returns to 0; each `row_done` is 515 cycles after the previous one.
- `start` asserted during SAMPLE and during DISPLAY → no effect; `row_done` timing is unchanged.
- Assert `rst`=0 asynchronously during bit 20's SETUP → `r_data`, `pclk` and `shift` drop to 0 and `oe` goes to 1 before the next edge. After release, a new `start` produces a full 64-bit row.
- `WIDTH`=4, `ON_CYCLES`=2 → 4 `pclk` pulses, 3 `shift` pulses, and `row_done` at N+20.
